// File: rtl/timer_bus_ctrl_pkg.sv
// Shared constants and types for the timer bus controller.
// Holds the address map, FSM encodings, decode targets and source bit indices.
package timer_bus_ctrl_pkg;

    localparam logic [31:0] T0_BASE   = 32'h0000_7F00;
    localparam logic [31:0] T0_LAST   = 32'h0000_7F0B;
    localparam logic [31:0] T1_BASE   = 32'h0000_7F10;
    localparam logic [31:0] T1_LAST   = 32'h0000_7F1B;
    localparam logic [31:0] PEND_ADDR = 32'h0000_7F20;
    localparam logic [31:0] MASK_ADDR = 32'h0000_7F24;
    localparam logic [31:0] VEC_ADDR  = 32'h0000_7F28;

    localparam int NUM_SRC = 3;
    localparam int SRC_T0  = 0;
    localparam int SRC_T1  = 1;
    localparam int SRC_EXT = 2;

    localparam logic [1:0] VEC_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        TGT_NONE = 3'd0,
        TGT_T0   = 3'd1,
        TGT_T1   = 3'd2,
        TGT_PEND = 3'd3,
        TGT_MASK = 3'd4,
        TGT_VEC  = 3'd5
    } target_t;

    // Misaligned addresses never hit a register, even inside a window.
    function automatic target_t decode(input logic [31:0] addr);
        target_t tgt;
        tgt = TGT_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr >= T0_BASE && addr <= T0_LAST) begin
                tgt = TGT_T0;
            end else if (addr >= T1_BASE && addr <= T1_LAST) begin
                tgt = TGT_T1;
            end else if (addr == PEND_ADDR) begin
                tgt = TGT_PEND;
            end else if (addr == MASK_ADDR) begin
                tgt = TGT_MASK;
            end else if (addr == VEC_ADDR) begin
                tgt = TGT_VEC;
            end
        end
        return tgt;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [NUM_SRC-1:0] v);
        logic [1:0] idx;
        idx = VEC_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/timer_bus_ctrl_irq_latch.sv
// Interrupt edge detection, pending/mask registers and vector encoding.
// Pending bits are sticky until cleared by a write-one-to-clear access.
module irq_latch
    import timer_bus_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [NUM_SRC-1:0] clr,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_din,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] hw_int,
    output logic [1:0]         vec
);

    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    logic               armed;

    // The first cycle after reset only primes prev, so a level already
    // high when reset drops is not mistaken for a fresh edge.
    assign rise = src & ~prev & {NUM_SRC{armed}};

    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= '0;
            armed   <= 1'b0;
            pending <= '0;
            mask    <= '0;
        end else begin
            prev    <= src;
            armed   <= 1'b1;
            pending <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_din;
            end
        end
    end

    assign hw_int = pending & mask;
    assign vec    = lowest_set(hw_int);

endmodule

// File: rtl/timer_bus_ctrl.sv
// Single-master bus bridge to two timers plus an interrupt controller.
// Every access takes IDLE -> ACCESS -> RESP, acking two cycles after the request.
module timer_bus_ctrl
    import timer_bus_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic [29:0] t0_addr,
    output logic        t0_we,
    output logic [31:0] t0_din,
    input  logic [31:0] t0_dout,
    output logic [29:0] t1_addr,
    output logic        t1_we,
    output logic [31:0] t1_din,
    input  logic [31:0] t1_dout,
    input  logic        t0_irq,
    input  logic        t1_irq,
    input  logic        ext_irq,
    output logic [2:0]  hw_int,
    output logic        irq_req
);

    state_t             state;
    target_t            target;
    target_t            dec;
    logic [29:0]        word_addr;
    logic [31:0]        wdata;
    logic               we;
    logic [31:0]        rd_mux;

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] clr;
    logic               mask_we;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [1:0]         vec;
    logic               reg_write;

    assign dec = decode(cpu_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            target    <= TGT_NONE;
            word_addr <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            t0_we     <= 1'b0;
            t1_we     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cpu_ack <= 1'b0;
                    if (cpu_req) begin
                        target    <= dec;
                        word_addr <= cpu_addr[31:2];
                        wdata     <= cpu_wdata;
                        we        <= cpu_we;
                        t0_we     <= cpu_we && (dec == TGT_T0);
                        t1_we     <= cpu_we && (dec == TGT_T1);
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    t0_we     <= 1'b0;
                    t1_we     <= 1'b0;
                    cpu_ack   <= 1'b1;
                    cpu_rdata <= we ? '0 : rd_mux;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    cpu_ack <= 1'b0;
                    t0_we   <= 1'b0;
                    t1_we   <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (target)
            TGT_T0:   rd_mux = t0_dout;
            TGT_T1:   rd_mux = t1_dout;
            TGT_PEND: rd_mux = {{(32-NUM_SRC){1'b0}}, pending};
            TGT_MASK: rd_mux = {{(32-NUM_SRC){1'b0}}, mask};
            TGT_VEC:  rd_mux = {30'b0, vec};
            default:  rd_mux = '0;
        endcase
    end

    // Register-file side effects happen only in the ACCESS cycle.
    assign reg_write = (state == ST_ACCESS) && we;
    assign clr       = (reg_write && target == TGT_PEND) ? wdata[NUM_SRC-1:0] : '0;
    assign mask_we   = reg_write && (target == TGT_MASK);

    assign src[SRC_T0]  = t0_irq;
    assign src[SRC_T1]  = t1_irq;
    assign src[SRC_EXT] = ext_irq;

    irq_latch u_irq_latch (
        .clk      (clk),
        .reset    (reset),
        .src      (src),
        .clr      (clr),
        .mask_we  (mask_we),
        .mask_din (wdata[NUM_SRC-1:0]),
        .pending  (pending),
        .mask     (mask),
        .hw_int   (hw_int),
        .vec      (vec)
    );

    assign irq_req = |hw_int;

    assign t0_addr = word_addr;
    assign t1_addr = word_addr;
    assign t0_din  = wdata;
    assign t1_din  = wdata;

endmodule

// File: tb/tb_timer_bus_ctrl.sv
// Self-checking bench for timer_bus_ctrl against a transaction-level model.
// Directed scenarios followed by randomized accesses and interrupt pulses.
module tb_timer_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic [29:0] t0_addr;
    logic        t0_we;
    logic [31:0] t0_din;
    logic [31:0] t0_dout;
    logic [29:0] t1_addr;
    logic        t1_we;
    logic [31:0] t1_din;
    logic [31:0] t1_dout;
    logic        t0_irq;
    logic        t1_irq;
    logic        ext_irq;
    logic [2:0]  hw_int;
    logic        irq_req;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] m_pend;
    logic [2:0] m_mask;

    logic        o_acc_ack;
    logic        o_t0_we;
    logic        o_t1_we;
    logic [29:0] o_t0_addr;
    logic [29:0] o_t1_addr;
    logic [31:0] o_t0_din;
    logic        o_ack;
    logic [31:0] o_rdata;
    logic        o_resp_we;
    logic        o_after_ack;

    timer_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .t0_addr   (t0_addr),
        .t0_we     (t0_we),
        .t0_din    (t0_din),
        .t0_dout   (t0_dout),
        .t1_addr   (t1_addr),
        .t1_we     (t1_we),
        .t1_din    (t1_din),
        .t1_dout   (t1_dout),
        .t0_irq    (t0_irq),
        .t1_irq    (t1_irq),
        .ext_irq   (ext_irq),
        .hw_int    (hw_int),
        .irq_req   (irq_req)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_vec(input logic [2:0] p, input logic [2:0] m);
        logic [2:0] v;
        v = p & m;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd3;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [31:0] d0,
                                             input logic [31:0] d1, input logic [2:0] p,
                                             input logic [2:0] m);
        if (a[1:0] != 2'b00) return 32'h0;
        if (a >= 32'h7F00 && a <= 32'h7F0B) return d0;
        if (a >= 32'h7F10 && a <= 32'h7F1B) return d1;
        if (a == 32'h7F20) return {29'h0, p};
        if (a == 32'h7F24) return {29'h0, m};
        if (a == 32'h7F28) return {30'h0, exp_vec(p, m)};
        return 32'h0;
    endfunction

    function automatic bit is_t0(input logic [31:0] a);
        return a[1:0] == 2'b00 && a >= 32'h7F00 && a <= 32'h7F0B;
    endfunction

    function automatic bit is_t1(input logic [31:0] a);
        return a[1:0] == 2'b00 && a >= 32'h7F10 && a <= 32'h7F1B;
    endfunction

    // Starts and ends one time unit after a rising edge with the FSM idle.
    task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [2:0] irq_acc);
        cpu_req = 1'b1;
        cpu_addr = a;
        cpu_we = w;
        cpu_wdata = d;
        @(posedge clk); #1;
        o_acc_ack = cpu_ack;
        o_t0_we = t0_we;
        o_t1_we = t1_we;
        o_t0_addr = t0_addr;
        o_t1_addr = t1_addr;
        o_t0_din = t0_din;
        cpu_addr = $urandom;
        cpu_we = 1'($urandom);
        cpu_wdata = $urandom;
        if (irq_acc != 3'b000) {ext_irq, t1_irq, t0_irq} = irq_acc;
        @(posedge clk); #1;
        o_ack = cpu_ack;
        o_rdata = cpu_rdata;
        o_resp_we = t0_we | t1_we;
        cpu_req = 1'b0;
        {ext_irq, t1_irq, t0_irq} = 3'b000;
        @(posedge clk); #1;
        o_after_ack = cpu_ack;
        if (w && a == 32'h7F20) m_pend = m_pend & ~d[2:0];
        if (w && a == 32'h7F24) m_mask = d[2:0];
        m_pend = m_pend | irq_acc;
    endtask

    task automatic pulse_src(input logic [2:0] bits);
        {ext_irq, t1_irq, t0_irq} = bits;
        @(posedge clk); #1;
        {ext_irq, t1_irq, t0_irq} = 3'b000;
        @(posedge clk); #1;
        m_pend = m_pend | bits;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({cpu_ack, t0_we, t1_we, irq_req} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 0000", {cpu_ack, t0_we, t1_we, irq_req});
        end
        vectors++;
        if (cpu_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata got %h want 0", cpu_rdata);
        end
        vectors++;
        if (hw_int !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hw_int got %b want 000", hw_int);
        end
        reset = 1'b0;
        m_pend = 3'b000;
        m_mask = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_timer_write;
        do_access(32'h7F04, 1'b1, 32'h10, 3'b000);
        vectors++;
        if (o_acc_ack !== 1'b0 || o_t0_we !== 1'b1 || o_t1_we !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_access ack/t0_we/t1_we got %b%b%b want 010",
                     o_acc_ack, o_t0_we, o_t1_we);
        end
        vectors++;
        if (o_t0_addr !== 30'h1FC1 || o_t0_din !== 32'h10) begin
            miscompares++;
            $display("FAIL wr_addr_din got %h/%h want 1fc1/10", o_t0_addr, o_t0_din);
        end
        vectors++;
        if (o_ack !== 1'b1 || o_resp_we !== 1'b0 || o_after_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_ack ack/we/after got %b%b%b want 100",
                     o_ack, o_resp_we, o_after_ack);
        end
    endtask

    task automatic test_timer_read;
        t1_dout = 32'hABCD;
        t0_dout = 32'h1234_5678;
        do_access(32'h7F18, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_ack !== 1'b1 || o_acc_ack !== 1'b0 || o_rdata !== 32'hABCD) begin
            miscompares++;
            $display("FAIL rd_t1 ack/rdata got %b/%h want 1/abcd", o_ack, o_rdata);
        end
        do_access(32'h7F30, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_ack !== 1'b1 || o_rdata !== 32'h0 || o_t0_we !== 1'b0 || o_t1_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_unmapped ack/rdata/we got %b/%h/%b%b want 1/0/00",
                     o_ack, o_rdata, o_t0_we, o_t1_we);
        end
        do_access(32'h7F06, 1'b1, 32'hFFFF_FFFF, 3'b000);
        vectors++;
        if (o_ack !== 1'b1 || o_t0_we !== 1'b0 || o_t1_we !== 1'b0 || hw_int !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_misaligned ack/we/hw got %b/%b%b/%b want 1/00/000",
                     o_ack, o_t0_we, o_t1_we, hw_int);
        end
    endtask

    task automatic test_irq_mask;
        do_access(32'h7F24, 1'b1, 32'hFFFF_FFFB, 3'b000);
        do_access(32'h7F24, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h3) begin
            miscompares++;
            $display("FAIL mask_read got %h want 3", o_rdata);
        end
        pulse_src(3'b010);
        do_access(32'h7F20, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h2 || hw_int !== 3'b010 || irq_req !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_t1 pend/hw/irq got %h/%b/%b want 2/010/1", o_rdata, hw_int, irq_req);
        end
        do_access(32'h7F28, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h1) begin
            miscompares++;
            $display("FAIL vec_t1 got %h want 1", o_rdata);
        end
        do_access(32'h7F20, 1'b1, 32'h2, 3'b000);
        do_access(32'h7F28, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h3 || hw_int !== 3'b000 || irq_req !== 1'b0) begin
            miscompares++;
            $display("FAIL w1c_t1 vec/hw/irq got %h/%b/%b want 3/000/0", o_rdata, hw_int, irq_req);
        end
    endtask

    task automatic test_w1c_race;
        pulse_src(3'b001);
        do_access(32'h7F20, 1'b1, 32'h1, 3'b001);
        do_access(32'h7F20, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h1 || m_pend !== 3'b001) begin
            miscompares++;
            $display("FAIL w1c_race pend got %h want 1", o_rdata);
        end
        do_access(32'h7F20, 1'b1, 32'h1, 3'b000);
        do_access(32'h7F20, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL w1c_clear pend got %h want 0", o_rdata);
        end
    endtask

    task automatic test_vec_priority;
        pulse_src(3'b111);
        do_access(32'h7F24, 1'b1, 32'h6, 3'b000);
        do_access(32'h7F28, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h1) begin
            miscompares++;
            $display("FAIL vec_mask6 got %h want 1", o_rdata);
        end
        do_access(32'h7F24, 1'b1, 32'h4, 3'b000);
        do_access(32'h7F28, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h2 || hw_int !== 3'b100) begin
            miscompares++;
            $display("FAIL vec_mask4 vec/hw got %h/%b want 2/100", o_rdata, hw_int);
        end
        do_access(32'h7F24, 1'b1, 32'h0, 3'b000);
        do_access(32'h7F28, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (irq_req !== 1'b0 || o_rdata !== 32'h3) begin
            miscompares++;
            $display("FAIL vec_mask0 irq/vec got %b/%h want 0/3", irq_req, o_rdata);
        end
        do_access(32'h7F20, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h7) begin
            miscompares++;
            $display("FAIL pend_raw got %h want 7", o_rdata);
        end
        do_access(32'h7F20, 1'b1, 32'h7, 3'b000);
    endtask

    task automatic test_reset_mid_access;
        cpu_req = 1'b1;
        cpu_addr = 32'h7F00;
        cpu_we = 1'b1;
        cpu_wdata = $urandom;
        @(posedge clk); #1;
        vectors++;
        if (t0_we !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre t0_we got %b want 1", t0_we);
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (t0_we !== 1'b0 || cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_rst we/ack got %b/%b want 0/0", t0_we, cpu_ack);
        end
        reset = 1'b0;
        m_pend = 3'b000;
        m_mask = 3'b000;
        repeat (2) begin
            @(posedge clk); #1;
            vectors++;
            if (t0_we !== 1'b0 || cpu_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_post we/ack got %b/%b want 0/0", t0_we, cpu_ack);
            end
        end
        do_access(32'h7F14, 1'b1, 32'h55, 3'b000);
        vectors++;
        if (o_acc_ack !== 1'b0 || o_t1_we !== 1'b1 || o_t0_we !== 1'b0 || o_ack !== 1'b1 ||
            o_t1_addr !== 30'h1FC5) begin
            miscompares++;
            $display("FAIL abort_next accack/t1we/t0we/ack/addr got %b%b%b%b/%h want 0101/1fc5",
                     o_acc_ack, o_t1_we, o_t0_we, o_ack, o_t1_addr);
        end
    endtask

    task automatic test_reset_src_high;
        ext_irq = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_pend = 3'b000;
        m_mask = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_addr = 32'h7F20;
        cpu_we = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL src_high_reset ack/pend got %b/%h want 1/0", cpu_ack, cpu_rdata);
        end
        ext_irq = 1'b0;
        @(posedge clk); #1;
        pulse_src(3'b100);
        do_access(32'h7F20, 1'b0, 32'h0, 3'b000);
        vectors++;
        if (o_rdata !== 32'h4) begin
            miscompares++;
            $display("FAIL src_rearm pend got %h want 4", o_rdata);
        end
        do_access(32'h7F20, 1'b1, 32'h4, 3'b000);
    endtask

    task automatic test_random;
        logic [31:0] addr_tbl [16];
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] want;
        logic        w;
        addr_tbl = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C, 32'h7F10, 32'h7F14,
                     32'h7F18, 32'h7F1C, 32'h7F20, 32'h7F24, 32'h7F28, 32'h7F2C,
                     32'h7F02, 32'h7F23, 32'h1000_7F00, 32'h0};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) pulse_src(3'($urandom_range(1, 7)));
            a = addr_tbl[$urandom_range(0, 15)];
            w = 1'($urandom);
            d = $urandom;
            t0_dout = $urandom;
            t1_dout = $urandom;
            want = exp_read(a, t0_dout, t1_dout, m_pend, m_mask);
            do_access(a, w, d, 3'b000);
            vectors++;
            if (o_acc_ack !== 1'b0 || o_ack !== 1'b1 || o_after_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_ack a=%h got %b%b%b want 010", a, o_acc_ack, o_ack, o_after_ack);
            end
            vectors++;
            if (o_t0_we !== (w & is_t0(a)) || o_t1_we !== (w & is_t1(a)) || o_resp_we !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_we a=%h w=%b got %b%b%b", a, w, o_t0_we, o_t1_we, o_resp_we);
            end
            if (!w) begin
                vectors++;
                if (o_rdata !== want) begin
                    miscompares++;
                    $display("FAIL rnd_rdata a=%h got %h want %h", a, o_rdata, want);
                end
            end
            vectors++;
            if (hw_int !== (m_pend & m_mask) || irq_req !== |(m_pend & m_mask)) begin
                miscompares++;
                $display("FAIL rnd_hw_int got %b/%b want %b", hw_int, irq_req, m_pend & m_mask);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = '0;
        cpu_we = 1'b0;
        cpu_wdata = '0;
        t0_dout = '0;
        t1_dout = '0;
        {ext_irq, t1_irq, t0_irq} = 3'b000;
        m_pend = 3'b000;
        m_mask = 3'b000;
        #1;
        test_reset;
        test_timer_write;
        test_timer_read;
        test_irq_mask;
        test_w1c_race;
        test_vec_priority;
        test_reset_mid_access;
        test_reset_src_high;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_bus_ctrl.md
TIMER_BUS_CTRL -- requirements
Module: timer_bus_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: cpu_req  input  1  access request; held high until cpu_ack.
REQ-004 SHALL have: cpu_addr  input  32  byte address of access.
REQ-005 SHALL have: cpu_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have: cpu_wdata  input  32  write data.
REQ-007 SHALL have: cpu_ack  output  1  one-cycle completion pulse.
REQ-008 SHALL have: cpu_rdata  output  32  read data, valid only while cpu_ack=1.
REQ-009 SHALL have: t0_addr/t1_addr  output  30  word address [31:2] to timer 0/1.
REQ-010 SHALL have: t0_we/t1_we  output  1  timer write enable.
REQ-011 SHALL have: t0_din/t1_din  output  32  timer write data.
REQ-012 SHALL have: t0_dout/t1_dout  input  32  combinational timer read data.
REQ-013 SHALL have: t0_irq, t1_irq, ext_irq  input  1  interrupt sources.
REQ-014 SHALL have: hw_int  output  3  masked pending vector {ext, t1, t0}.
REQ-015 SHALL have: irq_req  output  1  OR of hw_int.

Function
REQ-016 Address map SHALL be: 0x7F00-0x7F0B timer 0; 0x7F10-0x7F1B timer 1; 0x7F20 PEND; 0x7F24 MASK; 0x7F28 VEC; all other addresses, and any address with bits [1:0] != 0, unmapped.
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-018 IDLE: cpu_req=1 -> latch addr/we/wdata, decode target, go to ACCESS; cpu_req=0 -> stay.
REQ-019 ACCESS: assert the target timer's we for exactly this cycle on a timer write; capture read data into rdata register; go to RESP.
REQ-020 RESP: cpu_ack=1 for one cycle, cpu_rdata = captured data; go to IDLE unconditionally.
REQ-021 Latency SHALL be fixed: request sampled at edge N, cpu_ack high in cycle N+2; back-to-back requests give one ack every 3 cycles.
REQ-022 cpu_req and bus inputs SHALL be ignored in ACCESS and RESP.
REQ-023 t0_addr/t1_addr SHALL equal latched addr[31:2]; t*_din SHALL equal latched wdata; t*_we SHALL be 0 outside ACCESS and for non-target timers.
REQ-024 Unmapped access SHALL complete normally: no side effects, read data 0.
REQ-025 pending[i] SHALL set on a 0->1 transition of source i (registered previous value).
REQ-026 Write to PEND SHALL clear bits where wdata=1 (W1C) in the ACCESS cycle; a set edge in the same cycle SHALL win.
REQ-027 MASK SHALL be 3-bit read/write; wdata[31:3] ignored; reads return zero-extended.
REQ-028 hw_int SHALL equal pending & mask, combinational from registers.
REQ-029 VEC read SHALL return index of lowest set bit of hw_int (t0 > t1 > ext priority), or 3 when hw_int=0; writes ignored.
REQ-030 PEND read SHALL return raw (unmasked) pending, zero-extended.

Reset
REQ-031 Reset SHALL force state=IDLE, cpu_ack=0, cpu_rdata=0, t*_we=0, pending=0, mask=0, previous-source registers=0, hw_int=0, irq_req=0.
REQ-032 Reset asserted mid-access SHALL abort it: no ack issued, no timer write after the reset edge.
REQ-033 A source high while reset deasserts SHALL NOT set pending until it falls and rises again.

Structure
REQ-034 Shared package SHALL hold address-map constants, FSM state encodings, and source bit indices.
REQ-035 Edge detect, pending, mask and VEC logic SHALL be a sub-module irq_latch; bus FSM and decode stay in timer_bus_ctrl.

Verification
REQ-036 Write 0x7F04 data 0x10 (req at N) -> t0_we=1 with t0_addr=0x1FC1, t0_din=0x10 in cycle N+1 only; ack at N+2; t1_we stays 0.
REQ-037 Read 0x7F18 with t1_dout=0xABCD -> cpu_ack at N+2, cpu_rdata=0xABCD; read 0x7F30 -> rdata 0, no we.
REQ-038 MASK=0x3, pulse t1_irq -> PEND reads 0x2, hw_int=0b010, irq_req=1, VEC=1; write PEND 0x2 -> hw_int=0, VEC=3.
REQ-039 t0_irq rises in the same cycle a W1C of bit0 executes -> pending[0] remains 1.
REQ-040 All three sources pending with MASK=0x6 -> VEC=1; MASK=0x4 -> VEC=2; MASK=0 -> irq_req=0.
REQ-041 Reset asserted in ACCESS of a timer write -> no ack, t0_we=0 thereafter, next request completes normally with 2-cycle latency.
